// File: rtl/pcxt_clk_pkg.sv
// rtl/pcxt_clk_pkg.sv - shared types and helpers for the PCXT clock/reset controller
package pcxt_clk_pkg;

    typedef enum logic [1:0] {
        SPD_477  = 2'b00,
        SPD_716  = 2'b01,
        SPD_1431 = 2'b10
    } speed_t;

    typedef enum logic {
        SPL_SHOW,
        SPL_DONE
    } splash_state_t;

    typedef enum logic [1:0] {
        RST_SYS_HOLD,
        RST_CPU_HOLD,
        RST_RUN
    } rst_state_t;

    function automatic logic [1:0] speed_div(input speed_t spd);
        case (spd)
            SPD_716:  return 2'd2;
            SPD_1431: return 2'd1;
            default:  return 2'd3;
        endcase
    endfunction

    // The unused request code 11 falls back to the slowest, always-safe rate.
    function automatic speed_t speed_decode(input logic [1:0] req);
        return (req == 2'b11) ? SPD_477 : speed_t'(req);
    endfunction

endpackage

// File: rtl/pcxt_edge_sync.sv
// rtl/pcxt_edge_sync.sv - 3-flop synchroniser with registered rising-edge pulse
module pcxt_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic s1_q, s2_q, s3_q, pulse_q;
    logic s1_d, s2_d, s3_d, pulse_d;

    always_comb begin
        s1_d    = async_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pulse_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/pcxt_clock_reset_ctrl.sv
// rtl/pcxt_clock_reset_ctrl.sv - CPU/peripheral clock enables, splash timer and reset sequencing
module pcxt_clock_reset_ctrl
    import pcxt_clk_pkg::*;
#(
    parameter int N_EXT       = 3,
    parameter int SYS_RST_CYC = 65535,
    parameter int CPU_RST_CYC = 42,
    parameter int TICKS_PER_S = 14318000,
    parameter int SPLASH_S    = 5,
    parameter int PERIPH_DIV  = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ref_tick,
    input  logic [1:0]       speed_req,
    input  logic             biu_done,
    input  logic             soft_reset,
    input  logic             splash_skip,
    input  logic [N_EXT-1:0] ext_clk,
    output logic             cpu_ce,
    output logic             cpu_clk,
    output logic             periph_ce,
    output logic             periph_clk,
    output logic [1:0]       speed_cur,
    output logic [N_EXT-1:0] ext_ce,
    output logic             splash_active,
    output logic             sys_reset,
    output logic             cpu_reset
);

    localparam int TICK_W  = (TICKS_PER_S > 0) ? $clog2(TICKS_PER_S + 1) : 1;
    localparam int SEC_W   = (SPLASH_S > 0) ? $clog2(SPLASH_S + 1) : 1;
    localparam int PER_W   = $clog2(PERIPH_DIV + 1);
    localparam int RST_MAX = (SYS_RST_CYC > CPU_RST_CYC) ? SYS_RST_CYC : CPU_RST_CYC;
    localparam int RST_W   = $clog2(RST_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_S - 1);
    localparam logic [SEC_W-1:0]  SEC_END   = SEC_W'(SPLASH_S);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIPH_DIV - 1);
    localparam logic [PER_W-1:0]  PER_HALF  = PER_W'(PERIPH_DIV / 2);
    localparam logic [RST_W-1:0]  SYS_LAST  = RST_W'(SYS_RST_CYC - 1);
    localparam logic [RST_W-1:0]  CPU_LAST  = RST_W'(CPU_RST_CYC - 1);

    logic [1:0]        ph_q, ph_d;
    speed_t            speed_cur_q, speed_cur_d;
    logic              cpu_ce_q, cpu_ce_d, cpu_clk_q, cpu_clk_d;
    logic [PER_W-1:0]  pcnt_q, pcnt_d;
    logic              periph_ce_q, periph_ce_d, periph_clk_q, periph_clk_d;
    splash_state_t     spl_q, spl_d;
    logic [TICK_W-1:0] tcnt_q, tcnt_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    rst_state_t        rst_q, rst_d;
    logic [RST_W-1:0]  rcnt_q, rcnt_d;
    logic              sys_reset_q, sys_reset_d, cpu_reset_q, cpu_reset_d;

    speed_t            pending;
    logic              ph_wrap, pcnt_wrap, rst_src;

    // A speed change only retargets the divisor at a wrap, so the pulse that
    // closes the old period is always a full one and the next uses the new rate.
    always_comb begin
        pending     = speed_decode(speed_req);
        ph_wrap     = (ph_q == 2'(speed_div(speed_cur_q) - 2'd1));
        ph_d        = ph_q;
        speed_cur_d = speed_cur_q;
        cpu_clk_d   = cpu_clk_q;
        cpu_ce_d    = 1'b0;
        if (ref_tick) begin
            if (ph_wrap) begin
                ph_d     = 2'd0;
                cpu_ce_d = 1'b1;
                if (biu_done && (pending != speed_cur_q)) begin
                    speed_cur_d = pending;
                end
                cpu_clk_d = (speed_cur_d == SPD_477) ? 1'b1 : ~cpu_clk_q;
            end else begin
                ph_d = ph_q + 2'd1;
                if (speed_cur_q == SPD_477) begin
                    cpu_clk_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pcnt_wrap    = (pcnt_q == PER_LAST);
        pcnt_d       = pcnt_q;
        periph_ce_d  = 1'b0;
        periph_clk_d = periph_clk_q;
        if (ref_tick) begin
            pcnt_d      = pcnt_wrap ? '0 : pcnt_q + PER_W'(1);
            periph_ce_d = pcnt_wrap;
            if ((pcnt_d == '0) || (pcnt_d == PER_HALF)) begin
                periph_clk_d = ~periph_clk_q;
            end
        end
    end

    always_comb begin
        spl_d  = spl_q;
        tcnt_d = tcnt_q;
        sec_d  = sec_q;
        if (spl_q == SPL_SHOW) begin
            if ((sec_q == SEC_END) || splash_skip) begin
                spl_d = SPL_DONE;
            end else if (ref_tick) begin
                if (tcnt_q == TICK_LAST) begin
                    tcnt_d = '0;
                    sec_d  = sec_q + SEC_W'(1);
                end else begin
                    tcnt_d = tcnt_q + TICK_W'(1);
                end
            end
        end
    end

    // The splash screen doubles as a reset source so the machine boots only after it ends.
    always_comb begin
        rst_src = (spl_q == SPL_SHOW) | soft_reset;
        rst_d   = rst_q;
        rcnt_d  = rcnt_q;
        if (rst_src) begin
            rst_d  = RST_SYS_HOLD;
            rcnt_d = '0;
        end else begin
            case (rst_q)
                RST_SYS_HOLD: begin
                    if (rcnt_q == SYS_LAST) begin
                        rst_d  = RST_CPU_HOLD;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RST_W'(1);
                    end
                end
                RST_CPU_HOLD: begin
                    if (rcnt_q == CPU_LAST) begin
                        rst_d  = RST_RUN;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RST_W'(1);
                    end
                end
                RST_RUN: ;
                default: rst_d = RST_SYS_HOLD;
            endcase
        end
        sys_reset_d = (rst_d == RST_SYS_HOLD);
        cpu_reset_d = (rst_d != RST_RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ph_q         <= 2'd0;
            speed_cur_q  <= SPD_477;
            cpu_ce_q     <= 1'b0;
            cpu_clk_q    <= 1'b0;
            pcnt_q       <= '0;
            periph_ce_q  <= 1'b0;
            periph_clk_q <= 1'b0;
            if (SPLASH_S != 0) begin
                spl_q <= SPL_SHOW;
            end else begin
                spl_q <= SPL_DONE;
            end
            tcnt_q       <= '0;
            sec_q        <= '0;
            rst_q        <= RST_SYS_HOLD;
            rcnt_q       <= '0;
            sys_reset_q  <= 1'b1;
            cpu_reset_q  <= 1'b1;
        end else begin
            ph_q         <= ph_d;
            speed_cur_q  <= speed_cur_d;
            cpu_ce_q     <= cpu_ce_d;
            cpu_clk_q    <= cpu_clk_d;
            pcnt_q       <= pcnt_d;
            periph_ce_q  <= periph_ce_d;
            periph_clk_q <= periph_clk_d;
            spl_q        <= spl_d;
            tcnt_q       <= tcnt_d;
            sec_q        <= sec_d;
            rst_q        <= rst_d;
            rcnt_q       <= rcnt_d;
            sys_reset_q  <= sys_reset_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    for (genvar i = 0; i < N_EXT; i++) begin : g_ext
        pcxt_edge_sync u_sync (
            .clock    (clock),
            .reset_n  (reset_n),
            .async_in (ext_clk[i]),
            .pulse    (ext_ce[i])
        );
    end

    assign cpu_ce        = cpu_ce_q;
    assign cpu_clk       = cpu_clk_q;
    assign periph_ce     = periph_ce_q;
    assign periph_clk    = periph_clk_q;
    assign speed_cur     = speed_cur_q;
    assign splash_active = (spl_q == SPL_SHOW);
    assign sys_reset     = sys_reset_q;
    assign cpu_reset     = cpu_reset_q;

endmodule

// File: tb/tb_pcxt_clock_reset_ctrl.sv
// tb/tb_pcxt_clock_reset_ctrl.sv - directed self-checking bench for pcxt_clock_reset_ctrl
module tb_pcxt_clock_reset_ctrl;

    localparam int N_EXT = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             ref_tick;
    logic [1:0]       speed_req;
    logic             biu_done;
    logic             soft_reset;
    logic             splash_skip;
    logic [N_EXT-1:0] ext_clk;
    logic             cpu_ce, cpu_clk, periph_ce, periph_clk;
    logic [1:0]       speed_cur;
    logic [N_EXT-1:0] ext_ce;
    logic             splash_active, sys_reset, cpu_reset;

    int checks   = 0;
    int failures = 0;

    pcxt_clock_reset_ctrl #(
        .N_EXT       (N_EXT),
        .SYS_RST_CYC (8),
        .CPU_RST_CYC (4),
        .TICKS_PER_S (10),
        .SPLASH_S    (2),
        .PERIPH_DIV  (6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ref_tick      (ref_tick),
        .speed_req     (speed_req),
        .biu_done      (biu_done),
        .soft_reset    (soft_reset),
        .splash_skip   (splash_skip),
        .ext_clk       (ext_clk),
        .cpu_ce        (cpu_ce),
        .cpu_clk       (cpu_clk),
        .periph_ce     (periph_ce),
        .periph_clk    (periph_clk),
        .speed_cur     (speed_cur),
        .ext_ce        (ext_ce),
        .splash_active (splash_active),
        .sys_reset     (sys_reset),
        .cpu_reset     (cpu_reset)
    );

    always #5 clock = ~clock;

    // ref_tick: one clock in every four, changed well after the active edge
    int tick_ph = 0;
    initial begin
        ref_tick = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            tick_ph  = (tick_ph + 1) % 4;
            ref_tick = (tick_ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int   ce_since = 0, ce_gap = 0, ce_min = 1000;
    int   p_since = 0, p_gap = 0;
    int   ext1_pulses = 0, ext1_wide = 0, ext_other = 0;
    logic cpu_ce_prev = 1'b0, periph_ce_prev = 1'b0, ext1_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            chk("sys_implies_cpu_reset", !(sys_reset && !cpu_reset), 1);
            chk("cpu_ce_back_to_back", !(cpu_ce && cpu_ce_prev), 1);
            chk("periph_ce_back_to_back", !(periph_ce && periph_ce_prev), 1);
            if (cpu_ce) begin
                ce_gap = ce_since;
                if (ce_since < ce_min) ce_min = ce_since;
                ce_since = 1;
            end else begin
                ce_since++;
            end
            if (periph_ce) begin
                p_gap   = p_since;
                p_since = 1;
            end else begin
                p_since++;
            end
            if (ext_ce[1] && !ext1_prev) ext1_pulses++;
            if (ext_ce[1] && ext1_prev) ext1_wide++;
            if (ext_ce[0] || ext_ce[2]) ext_other++;
            cpu_ce_prev    = cpu_ce;
            periph_ce_prev = periph_ce;
            ext1_prev      = ext_ce[1];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_ce(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 400) begin
            step(1);
            if (cpu_ce) seen++;
            budget++;
        end
        if (seen < n) chk("wait_ce_timeout", seen, n);
    endtask

    task automatic count_high_cpu_clk(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step(1);
            if (cpu_clk) hi++;
        end
    endtask

    task automatic measure_release(input string tag);
        int n = 0;
        while (sys_reset && n < 100) begin
            step(1);
            n++;
        end
        chk({tag, "_sys_release"}, n, 8);
        n = 0;
        while (cpu_reset && n < 100) begin
            step(1);
            n++;
        end
        chk({tag, "_cpu_release"}, n, 4);
    endtask

    initial begin
        int ticks;
        int budget;
        int hi;

        reset_n     = 1'b0;
        speed_req   = 2'b00;
        biu_done    = 1'b1;
        soft_reset  = 1'b0;
        splash_skip = 1'b0;
        ext_clk     = '0;
        step(3);

        chk("rst_cpu_ce", cpu_ce, 0);
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_periph_ce", periph_ce, 0);
        chk("rst_periph_clk", periph_clk, 0);
        chk("rst_speed_cur", speed_cur, 0);
        chk("rst_ext_ce", ext_ce, 0);
        chk("rst_splash_active", splash_active, 1);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_cpu_reset", cpu_reset, 1);

        // splash lasts exactly 2 s * 10 ticks, then the reset sequence runs
        reset_n = 1'b1;
        ticks   = 0;
        budget  = 0;
        while (splash_active && budget < 500) begin
            if (ref_tick) ticks++;
            step(1);
            budget++;
        end
        chk("splash_ticks", ticks, 20);
        measure_release("boot");

        wait_ce(3);
        chk("speed_477_cur", speed_cur, 0);
        chk("speed_477_gap", ce_gap, 12);
        count_high_cpu_clk(12, hi);
        chk("speed_477_duty", hi, 4);

        ce_min    = 1000;
        speed_req = 2'b10;
        wait_ce(4);
        chk("speed_1431_cur", speed_cur, 2);
        chk("speed_1431_gap", ce_gap, 4);
        chk("switch_min_gap_ge4", ce_min >= 4, 1);

        biu_done  = 1'b0;
        speed_req = 2'b01;
        step(50);
        chk("biu_busy_hold_cur", speed_cur, 2);
        chk("biu_busy_hold_gap", ce_gap, 4);
        biu_done = 1'b1;
        wait_ce(4);
        chk("speed_716_cur", speed_cur, 1);
        chk("speed_716_gap", ce_gap, 8);
        count_high_cpu_clk(16, hi);
        chk("speed_716_duty", hi, 8);

        chk("periph_gap", p_gap, 24);
        hi = 0;
        for (int k = 0; k < 24; k++) begin
            step(1);
            if (periph_clk) hi++;
        end
        chk("periph_clk_duty", hi, 12);

        speed_req = 2'b11;
        wait_ce(4);
        chk("speed_11_cur", speed_cur, 0);
        chk("speed_11_gap", ce_gap, 12);

        // 1 MHz asynchronous clock on bit 1 only
        ext1_pulses = 0;
        ext1_wide   = 0;
        ext_other   = 0;
        #3;
        repeat (20) begin
            ext_clk[1] = 1'b1;
            #497;
            ext_clk[1] = 1'b0;
            #503;
        end
        step(10);
        chk("ext1_pulses", ext1_pulses, 20);
        chk("ext1_wide", ext1_wide, 0);
        chk("ext_other_bits", ext_other, 0);

        reset_n = 1'b0;
        step(2);
        chk("rerst_splash_active", splash_active, 1);
        reset_n = 1'b1;
        step(4);
        chk("pre_skip_splash_active", splash_active, 1);
        splash_skip = 1'b1;
        step(1);
        splash_skip = 1'b0;
        chk("skip_splash_active", splash_active, 0);
        measure_release("skip");

        // re-enter CPU_HOLD, then interrupt it with a soft reset
        reset_n = 1'b0;
        step(1);
        reset_n     = 1'b1;
        splash_skip = 1'b1;
        step(1);
        splash_skip = 1'b0;
        budget = 0;
        while (sys_reset && budget < 100) begin
            step(1);
            budget++;
        end
        chk("soft_pre_sys_reset", sys_reset, 0);
        step(2);
        chk("soft_pre_cpu_reset", cpu_reset, 1);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        chk("soft_sys_reset", sys_reset, 1);
        chk("soft_cpu_reset", cpu_reset, 1);
        measure_release("soft");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
